// File: rtl/usb_token_tx.sv
// usb_token_tx: serializes one USB token packet (SYNC, PID, ADDR, ENDP, CRC5)
// one bit per bit_strobe, feeding the NRZI/bit-stuff line encoder.
module usb_token_tx #(
    parameter logic [7:0] SYNC_PATTERN = 8'h80,
    parameter logic [4:0] CRC_INIT     = 5'h1F
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [3:0] pid,
    input  logic [6:0] addr,
    input  logic [3:0] endp,
    input  logic       bit_strobe,
    output logic       tx_bit,
    output logic       tx_active,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PID,
        TOKEN,
        CRC
    } state_t;

    state_t      state;
    logic [3:0]  pid_q;
    logic [6:0]  addr_q;
    logic [3:0]  endp_q;
    logic [4:0]  crc;
    logic [3:0]  cnt;

    logic [7:0]  pid_byte;
    logic [10:0] token;
    logic [3:0]  nxt;
    logic        crc_fb;
    logic [4:0]  crc_nxt;
    logic [2:0]  crc_idx;

    assign pid_byte = {~pid_q, pid_q};
    assign token    = {endp_q, addr_q};
    assign nxt      = cnt + 4'd1;

    // CRC absorbs the bit currently on the line as it is consumed
    assign crc_fb   = crc[4] ^ tx_bit;
    assign crc_nxt  = {crc[3:0], 1'b0} ^ (crc_fb ? 5'b00101 : 5'b00000);

    // CRC bits go out MSB first and inverted; next index after cnt
    assign crc_idx  = 3'd3 - cnt[2:0];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            pid_q     <= '0;
            addr_q    <= '0;
            endp_q    <= '0;
            crc       <= CRC_INIT;
            cnt       <= '0;
            tx_bit    <= 1'b0;
            tx_active <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // a request in the done cycle is dropped, not deferred
                    if (start && !done) begin
                        pid_q     <= pid;
                        addr_q    <= addr;
                        endp_q    <= endp;
                        crc       <= CRC_INIT;
                        cnt       <= '0;
                        state     <= SYNC;
                        tx_bit    <= SYNC_PATTERN[0];
                        tx_active <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SYNC: begin
                    if (bit_strobe) begin
                        if (cnt == 4'd7) begin
                            cnt    <= '0;
                            state  <= PID;
                            tx_bit <= pid_byte[0];
                        end else begin
                            cnt    <= nxt;
                            tx_bit <= SYNC_PATTERN[nxt[2:0]];
                        end
                    end
                end
                PID: begin
                    if (bit_strobe) begin
                        if (cnt == 4'd7) begin
                            cnt    <= '0;
                            state  <= TOKEN;
                            tx_bit <= token[0];
                        end else begin
                            cnt    <= nxt;
                            tx_bit <= pid_byte[nxt[2:0]];
                        end
                    end
                end
                TOKEN: begin
                    if (bit_strobe) begin
                        crc <= crc_nxt;
                        if (cnt == 4'd10) begin
                            cnt    <= '0;
                            state  <= CRC;
                            tx_bit <= ~crc_nxt[4];
                        end else begin
                            cnt    <= nxt;
                            tx_bit <= token[nxt];
                        end
                    end
                end
                CRC: begin
                    if (bit_strobe) begin
                        if (cnt == 4'd4) begin
                            cnt       <= '0;
                            state     <= IDLE;
                            tx_bit    <= 1'b0;
                            tx_active <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            cnt    <= nxt;
                            tx_bit <= ~crc[crc_idx];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
